// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: PC owner and IF stage, req/ack fetch with branch redirects.
// Optional watchdog enabled by defining FETCH_TIMEOUT_EN.
module ins_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  control,
  input  logic        branchFlag,
  input  logic [31:0] branchTarget,
  output logic        instMemReq,
  output logic [31:0] instMemAddr,
  input  logic        instMemAck,
  input  logic [31:0] instMemData,
  output logic [31:0] insFetchPC,
  output logic [31:0] insFetchInst,
  output logic        stallReq,
  output logic        fetchErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pendValid;
  logic [31:0] r_pendTarget;
  logic [31:0] r_fPC;
  logic [31:0] r_fInst;

  logic        w_ackOk;
  logic        w_reqOn;
  logic        w_inReq;
  logic        w_stall0;
  logic [31:0] w_brTgt;
  logic [31:0] w_nextPc;
  logic        w_unused;

  assign w_inReq  = (r_state == S_REQ);
  assign w_stall0 = control[0];
  assign w_brTgt  = {branchTarget[31:2], 2'b00};
  assign w_unused = ^{control[5:1], branchTarget[1:0]};

`ifdef FETCH_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  logic [31:0] r_tmoCnt;
  logic        r_hold;
  logic        r_err;

  // Watchdog: after TMO_LAST+1 silent cycles drop the request for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmoCnt <= '0;
      r_hold   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_inReq) begin
      if (r_hold) begin
        r_hold <= 1'b0;
      end else if (instMemAck) begin
        r_tmoCnt <= '0;
      end else if (r_tmoCnt == TMO_LAST) begin
        r_tmoCnt <= '0;
        r_hold   <= 1'b1;
        r_err    <= 1'b1;
      end else begin
        r_tmoCnt <= r_tmoCnt + 32'd1;
      end
    end else begin
      r_tmoCnt <= '0;
      r_hold   <= 1'b0;
    end
  end

  assign w_ackOk  = instMemAck & ~r_hold;
  assign w_reqOn  = ~r_hold;
  assign fetchErr = r_err;
`else
  assign w_ackOk  = instMemAck;
  assign w_reqOn  = 1'b1;
  assign fetchErr = 1'b0;
`endif

  // Redirect priority: live branch, then pending redirect, then sequential.
  always_comb begin
    w_nextPc = r_pc + 32'd4;
    if (branchFlag) begin
      w_nextPc = w_brTgt;
    end else if (r_pendValid) begin
      w_nextPc = r_pendTarget;
    end
  end

  // Fetch FSM with registered IF/ID outputs and redirect bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_pendValid  <= 1'b0;
      r_pendTarget <= '0;
      r_fPC        <= '0;
      r_fInst      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (branchFlag) begin
            r_pendValid  <= 1'b1;
            r_pendTarget <= w_brTgt;
          end
          if (w_ackOk) begin
            r_state <= S_DONE;
            if (!r_pendValid && !branchFlag) begin
              r_fInst <= instMemData;
              r_fPC   <= r_pc;
            end else begin
              r_fInst <= '0;
            end
          end
        end
        S_DONE: begin
          if (!w_stall0) begin
            r_pc        <= w_nextPc;
            r_pendValid <= 1'b0;
            r_fInst     <= '0;
            r_state     <= S_REQ;
          end else if (branchFlag) begin
            r_pendValid  <= 1'b1;
            r_pendTarget <= w_brTgt;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instMemReq   = w_inReq & w_reqOn;
  assign instMemAddr  = r_pc;
  assign stallReq     = w_inReq & ~w_ackOk;
  assign insFetchPC   = r_fPC;
  assign insFetchInst = r_fInst;

endmodule
